// File: rtl/psum_accum_if.sv
// Handshake bundle between the upstream MAC stage, the partial-sum
// accumulator and its downstream consumer.
interface psum_accum_if #(
   parameter int ACC_W = 20
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      prod;
   logic [7:0]       index;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [7:0]       out_index;
   logic             err_drop;

   // Upstream/downstream side: drives beats and drain acceptance.
   modport master (
      output in_valid, prod, index, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_index, err_drop
   );

   // Accumulator side.
   modport slave (
      input  in_valid, prod, index, in_last, out_ready,
      output in_ready, out_valid, out_data, out_index, err_drop
   );
endinterface

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums unsigned products into OUT_LEN saturating
// bins during a row, then drains every bin in ascending order and clears it.
module psum_accum #(
   parameter  int ROW_LENGTH  = 28,
   parameter  int FILTER_SIZE = 5,
   parameter  int ACC_W       = 20,
   localparam int OUT_LEN     = ROW_LENGTH - FILTER_SIZE + 1,
   localparam int PTR_W       = $clog2(OUT_LEN)
) (
   input logic          clk,
   input logic          rst,
   psum_accum_if.slave  bus
);

   typedef enum logic {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [ACC_W-1:0] acc [OUT_LEN];
   logic [PTR_W-1:0] ptr;
   logic             err_q;

   logic             accept;
   logic             in_range;
   logic [PTR_W-1:0] wr_idx;
   logic [ACC_W:0]   sum_wide;
   logic [ACC_W-1:0] sum_sat;
   logic             drain_hs;
   logic             drain_done;

   // Beats are only taken in ACCUM; in DRAIN in_valid/in_last are ignored.
   assign accept     = bus.in_valid && (state == ACCUM);
   assign in_range   = int'(bus.index) < OUT_LEN;
   assign wr_idx     = in_range ? bus.index[PTR_W-1:0] : '0;

   // One extra bit of headroom exposes the carry used for saturation.
   assign sum_wide   = {1'b0, acc[wr_idx]} + (ACC_W+1)'(bus.prod);
   assign sum_sat    = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];

   assign drain_hs   = (state == DRAIN) && bus.out_ready;
   assign drain_done = drain_hs && (ptr == PTR_W'(OUT_LEN - 1));

   assign bus.err_drop = err_q;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (rst) state <= ACCUM;
      else     state <= state_next;
   end

   // Next-state: last accepted beat starts a drain, final handshake ends it.
   always_comb begin
      // NOTE: default first, so no path leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         ACCUM: if (accept && bus.in_last) state_next = DRAIN;
         DRAIN: if (drain_done)            state_next = ACCUM;
         default:                          state_next = ACCUM;
      endcase
   end

   // Outputs: ready while accumulating, presenting acc[ptr] while draining.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_index = '0;
      case (state)
         ACCUM: bus.in_ready = 1'b1;
         DRAIN: begin
            bus.out_valid = 1'b1;
            bus.out_data  = acc[ptr];
            bus.out_index = 8'(ptr);
         end
         default: ;
      endcase
   end

   // Drain pointer: advances per handshake, wraps to 0 after the last bin.
   always_ff @(posedge clk) begin
      if (rst)             ptr <= '0;
      else if (drain_done) ptr <= '0;
      else if (drain_hs)   ptr <= ptr + PTR_W'(1);
   end

   // Accumulator bins: saturating add on accept, clear-on-read while draining.
   always_ff @(posedge clk) begin
      // NOTE: this array is reset explicitly because a drain must never see
      // stale sums after rst; it therefore maps to flops, not a RAM macro.
      if (rst) begin
         for (int i = 0; i < OUT_LEN; i++) acc[i] <= '0;
      end else if (accept && in_range) begin
         acc[wr_idx] <= sum_sat;
      end else if (drain_hs) begin
         acc[ptr] <= '0;
      end
   end

   // Sticky drop flag for beats addressed beyond the last output position.
   always_ff @(posedge clk) begin
      if (rst)                        err_q <= 1'b0;
      else if (accept && !in_range)   err_q <= 1'b1;
   end

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: directed scenarios plus random rows,
// compared against a bin-array reference model.
module tb_psum_accum;

   localparam int          OUT_LEN = 24;
   localparam int unsigned MAXV    = (1 << 20) - 1;

   logic clk;
   logic rst;

   psum_accum_if #(.ACC_W(20)) bus ();

   psum_accum dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned model_acc [OUT_LEN];
   bit          model_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < OUT_LEN; i++) model_acc[i] = 0;
      model_err = 1'b0;
   endtask

   // Drives one beat starting just after a rising edge; returns just after
   // the edge that accepted it.
   task automatic beat(input int unsigned p, input int unsigned idx, input bit last);
      bus.in_valid = 1'b1;
      bus.prod     = 16'(p);
      bus.index    = 8'(idx);
      bus.in_last  = last;
      @(negedge clk);
      check("in_ready_accum", 32'(bus.in_ready), 32'd1);
      check("err_drop_accum", 32'(bus.err_drop), 32'(model_err));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (idx < OUT_LEN) begin
         if (model_acc[idx] + p > MAXV) model_acc[idx] = MAXV;
         else                           model_acc[idx] = model_acc[idx] + p;
      end else begin
         model_err = 1'b1;
      end
   endtask

   // Drains one row. mode 0: out_ready always 1; 1: pattern 1,0,0; 2: random.
   // Junk beats are offered throughout and must be ignored.
   task automatic drain(input int mode);
      int exp_ptr = 0;
      int cyc     = 0;
      while (exp_ptr < OUT_LEN && cyc < 400) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 3 == 0);
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_last  = 1'($urandom_range(0, 1));
         bus.prod     = 16'($urandom_range(1, 65535));
         bus.index    = 8'($urandom_range(0, OUT_LEN - 1));
         @(negedge clk);
         check("out_valid_drain", 32'(bus.out_valid), 32'd1);
         check("in_ready_drain",  32'(bus.in_ready),  32'd0);
         check($sformatf("out_index_%0d", exp_ptr), 32'(bus.out_index), 32'(exp_ptr));
         check($sformatf("out_data_%0d", exp_ptr),  32'(bus.out_data),  model_acc[exp_ptr]);
         check("err_drop_drain",  32'(bus.err_drop),  32'(model_err));
         @(posedge clk);
         #1;
         if (bus.out_ready) begin
            model_acc[exp_ptr] = 0;
            exp_ptr++;
         end
         cyc++;
      end
      if (exp_ptr < OUT_LEN) check("drain_timeout", 32'(exp_ptr), 32'(OUT_LEN));
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("out_valid_after", 32'(bus.out_valid), 32'd0);
      check("in_ready_after",  32'(bus.in_ready),  32'd1);
      check("err_drop_after",  32'(bus.err_drop),  32'(model_err));
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
      check({tag, "_out_index"}, 32'(bus.out_index), 32'd0);
      check({tag, "_err_drop"},  32'(bus.err_drop),  32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.prod      = '0;
      bus.index     = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle("reset");

      // Single beat pair into one bin.
      beat(100, 3, 1'b0);
      beat(50, 3, 1'b1);
      check("single_bin3_model", model_acc[3], 32'd150);
      drain(0);

      // Saturation of bin 0.
      for (int k = 0; k < 20; k++) beat(65025, 0, k == 19);
      drain(0);

      // Out-of-range index sets the sticky flag.
      beat(7, 24, 1'b1);
      drain(0);

      // Backpressure with out_ready pattern 1,0,0.
      beat(11, 0, 1'b0);
      beat(22, 12, 1'b0);
      beat(33, 23, 1'b1);
      drain(1);

      // Clear on drain: row A then row B.
      beat(9, 5, 1'b1);
      drain(0);
      beat(1, 6, 1'b1);
      drain(0);

      // Reset in the middle of a drain at ptr = 10.
      beat(5, 12, 1'b1);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("pre_rst_index", 32'(bus.out_index), 32'(k));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("pre_rst_ptr10", 32'(bus.out_index), 32'd10);
      rst           = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      check_idle("mid_drain_rst");
      beat(2, 10, 1'b1);
      drain(0);

      // Random rows against the model.
      for (int r = 0; r < 8; r++) begin
         int nb = $urandom_range(1, 40);
         for (int k = 0; k < nb; k++) begin
            int unsigned p   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 65535) : $urandom_range(0, 15);
            int unsigned idx = ($urandom_range(0, 9) == 0) ? $urandom_range(OUT_LEN, 255) : $urandom_range(0, OUT_LEN - 1);
            beat(p, idx, k == nb - 1);
         end
         drain(2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
